tcb_full_lib_sram_sub: RTL and testbench

- TCB-Full subordinate endpoint that terminates a TCB bus on a synchronous single-port SRAM macro.
- Sits directly downstream of a TCB-Full interface configured as byte-enable mode, half-duplex channel, response delay DLY=1.
- Adds programmable wait states, out-of-range error detection, and optional read-data hold.
- Serves as the standard memory leaf for instruction and data buses.

---
 rtl/tcb_full_lib_sram_sub.sv | 71 +++++++
 tb/tb_tcb_full_lib_sram_sub.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/tcb_full_lib_sram_sub.sv
// tcb_full_lib_sram_sub: TCB-Full subordinate terminating on a single-port SRAM,
// with programmable wait states, out-of-range errors and optional read-data hold.
module tcb_full_lib_sram_sub #(
  parameter int ADR  = 32,
  parameter int DAT  = 32,
  parameter int SIZ  = 4096,
  parameter int WAIT = 0,
  parameter int HLD  = 1,
  localparam int BW  = DAT/8,
  localparam int SL  = $clog2(SIZ),
  localparam int OFF = $clog2(BW),
  localparam int AW  = SL - OFF
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           tcb_vld,
  output logic           tcb_rdy,
  input  logic           tcb_wen,
  input  logic [ADR-1:0] tcb_adr,
  input  logic [BW-1:0]  tcb_byt,
  input  logic [DAT-1:0] tcb_wdt,
  output logic [DAT-1:0] tcb_rdt,
  output logic           tcb_err,
  output logic           sram_cen,
  output logic           sram_wen,
  output logic [AW-1:0]  sram_adr,
  output logic [BW-1:0]  sram_ben,
  output logic [DAT-1:0] sram_wdt,
  input  logic [DAT-1:0] sram_rdt
);
  typedef enum logic {IDL, STL} state_t;
  state_t         state;
  logic [3:0]     cnt;
  logic           rd_q, err_q, trn, oor;
  logic [DAT-1:0] hold;
  assign oor      = (tcb_adr >> SL) != '0;
  assign tcb_rdy  = (WAIT == 0) ? ~rst : (state == STL) && (cnt == 4'd0);
  assign trn      = tcb_vld & tcb_rdy;
  assign sram_cen = trn & ~oor;
  assign sram_wen = trn & tcb_wen & ~oor;
  assign sram_adr = tcb_adr[SL-1:OFF];
  assign sram_ben = tcb_byt;
  assign sram_wdt = tcb_wdt;
  assign tcb_err  = err_q;
  assign tcb_rdt  = rd_q ? sram_rdt : (HLD != 0) ? hold : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDL;
      cnt   <= '0;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
      hold  <= '0;
    end else begin
      rd_q  <= trn & ~tcb_wen & ~oor;
      err_q <= trn & oor;
      if (rd_q) hold <= sram_rdt;
      if (WAIT != 0) begin
        if (state == IDL) begin
          if (tcb_vld) begin
            state <= STL;
            cnt   <= 4'(WAIT-1);
          end
        end else if (trn) state <= IDL;
        // manager dropped the request mid-stall: abandon it without touching the SRAM
        else if (!tcb_vld) begin
          state <= IDL;
          cnt   <= '0;
        end else if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
    end
endmodule

// File: tb/tb_tcb_full_lib_sram_sub.sv
// tb_tcb_full_lib_sram_sub: three configurations (WAIT=0/HLD=1, WAIT=2/HLD=0, WAIT=3/HLD=1)
// each on its own SRAM model, checked against a response scoreboard.
module tb_tcb_full_lib_sram_sub;
  typedef struct packed {logic err; logic rd; logic [31:0] rdt;} exp_t;
  logic        clk = 0;
  logic        rst [3];
  logic        vld [3], rdy [3], wen [3], err [3], cen [3], swen [3];
  logic [31:0] adr [3], wdt [3], rdt [3], swdt [3], srdt [3];
  logic [3:0]  byt [3], ben [3];
  logic [9:0]  sadr [3];
  logic [31:0] last [3];
  logic        pend [3];
  exp_t        q [$];
  int          nchk = 0, nerr = 0, w;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gi
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
      if (cen[g] & swen[g])
        for (int b = 0; b < 4; b++) if (ben[g][b]) mem[sadr[g]][8*b +: 8] <= swdt[g][8*b +: 8];
      srdt[g] <= (cen[g] & ~swen[g]) ? mem[sadr[g]] : $urandom;
    end
    tcb_full_lib_sram_sub #(.WAIT(g == 0 ? 0 : g == 1 ? 2 : 3), .HLD(g == 1 ? 0 : 1)) dut (
      .clk(clk), .rst(rst[g]), .tcb_vld(vld[g]), .tcb_rdy(rdy[g]), .tcb_wen(wen[g]),
      .tcb_adr(adr[g]), .tcb_byt(byt[g]), .tcb_wdt(wdt[g]), .tcb_rdt(rdt[g]), .tcb_err(err[g]),
      .sram_cen(cen[g]), .sram_wen(swen[g]), .sram_adr(sadr[g]), .sram_ben(ben[g]),
      .sram_wdt(swdt[g]), .sram_rdt(srdt[g]));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // response checker: pops the scoreboard one cycle after each transfer, otherwise checks idle response
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [31:0] idle;
      idle = (k == 1) ? 32'h0 : last[k];
      if (pend[k]) begin
        exp_t e;
        if (q.size() == 0) begin
          chk($sformatf("scoreboard_empty%0d", k), 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          chk($sformatf("rsp_err%0d", k), {31'd0, err[k]}, {31'd0, e.err});
          chk($sformatf("rsp_rdt%0d", k), rdt[k], e.rd ? e.rdt : idle);
          if (e.rd) last[k] = e.rdt;
        end
      end else begin
        chk($sformatf("idle_err%0d", k), {31'd0, err[k]}, 32'd0);
        chk($sformatf("idle_rdt%0d", k), rdt[k], idle);
      end
      pend[k] = vld[k] & rdy[k];
    end
  end
  task automatic req(input int k, input logic wr, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [31:0] ex, output int waits);
    exp_t e;
    logic o;
    o = a >= 32'd4096;
    e.err = o; e.rd = ~wr & ~o; e.rdt = ex;
    q.push_back(e);
    vld[k] = 1; wen[k] = wr; adr[k] = a; byt[k] = b; wdt[k] = d;
    waits = 0;
    @(negedge clk);
    while (!rdy[k] && waits < 20) begin
      chk("stall_cen", {31'd0, cen[k]}, 32'd0);
      waits++;
      @(negedge clk);
    end
    if (!rdy[k]) begin
      chk("rdy_timeout", 32'd0, 32'd1);
      q.delete();
    end
    chk("trn_cen", {31'd0, cen[k]}, {31'd0, ~o});
    chk("trn_swen", {31'd0, swen[k]}, {31'd0, wr & ~o});
    if (!o) chk("trn_sadr", {22'd0, sadr[k]}, {22'd0, a[11:2]});
    @(posedge clk); #1;
    vld[k] = 0;
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1; vld[k] = 0; wen[k] = 0; adr[k] = 0; byt[k] = 0; wdt[k] = 0;
      last[k] = 0; pend[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_rdy", {31'd0, rdy[k]}, 32'd0);
      chk("reset_cen", {31'd0, cen[k]}, 32'd0);
      chk("reset_err", {31'd0, err[k]}, 32'd0);
      chk("reset_rdt", rdt[k], 32'd0);
      rst[k] = 0;
    end
    @(posedge clk); #1;
    req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, w);              chk("w0_waits", w, 0);
    req(0, 0, 32'h10, 4'hF, 0, 32'hDEADBEEF, w);              chk("w0_waits", w, 0);
    req(0, 1, 32'h20, 4'hF, 32'h11223344, 0, w);
    req(0, 1, 32'h20, 4'b0010, 32'h0000AA00, 0, w);
    req(0, 0, 32'h20, 4'hF, 0, 32'h1122AA44, w);
    req(0, 0, 32'h20, 4'hF, 0, 32'h1122AA44, w);
    req(0, 1, 32'h20, 4'hF, 32'h55667788, 0, w);
    req(0, 0, 32'h20, 4'hF, 0, 32'h55667788, w);
    req(0, 1, 32'h30, 4'hF, 32'hCAFEF00D, 0, w);
    req(0, 0, 32'h30, 4'hF, 0, 32'hCAFEF00D, w);
    req(0, 0, 32'h1000, 4'hF, 0, 0, w);
    req(0, 1, 32'h1004, 4'hF, 32'h12345678, 0, w);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_rdt", rdt[0], 32'hCAFEF00D);
    req(1, 1, 32'h40, 4'hF, 32'hA5A5_5A5A, 0, w);             chk("w2_waits", w, 2);
    req(1, 0, 32'h40, 4'hF, 0, 32'hA5A5_5A5A, w);             chk("w2_waits_b2b", w, 2);
    req(1, 0, 32'h1000, 4'hF, 0, 0, w);                       chk("w2_oor_waits", w, 2);
    repeat (3) @(posedge clk);
    #1;
    vld[2] = 1; wen[2] = 0; adr[2] = 32'h50; byt[2] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("stl_rdy", {31'd0, rdy[2]}, 32'd0);
    #2 rst[2] = 1;
    #1 chk("rst_rdy", {31'd0, rdy[2]}, 32'd0);
    @(negedge clk) chk("rst_cen", {31'd0, cen[2]}, 32'd0);
    vld[2] = 0;
    @(posedge clk); #1;
    rst[2] = 0;
    last[2] = 0;
    repeat (3) begin
      @(negedge clk) chk("post_rst_cen", {31'd0, cen[2]}, 32'd0);
    end
    @(posedge clk); #1;
    req(2, 1, 32'h50, 4'hF, 32'h0BAD_F00D, 0, w);             chk("w3_waits", w, 3);
    req(2, 0, 32'h50, 4'hF, 0, 32'h0BAD_F00D, w);             chk("w3_waits", w, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
